// File: rtl/lzc_norm_seq.sv
// Sequenced mantissa normalizer: a narrow LZC scans CHUNK bits
// per cycle from the MSB, then one shift/exponent-adjust cycle.

module lzc #(
  parameter int unsigned WIDTH = 16,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o,
  output logic             empty_o
);

  // MODE=1 counts leading zeros, MODE=0 counts trailing zeros
  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (MODE) begin
        if (in_i[i]) cnt_o = CW'(int'(WIDTH) - 1 - i);
      end else begin
        if (in_i[int'(WIDTH) - 1 - i]) cnt_o = CW'(int'(WIDTH) - 1 - i);
      end
    end
  end

endmodule

module lzc_norm_seq #(
  parameter int unsigned WIDTH     = 48,
  parameter int unsigned CHUNK     = 16,
  parameter int unsigned EXP_WIDTH = 10,
  parameter int unsigned TAG_WIDTH = 2,
  localparam int unsigned CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     mant_i,
  input  logic [EXP_WIDTH-1:0] exp_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     mant_o,
  output logic [EXP_WIDTH-1:0] exp_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 zero_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned LCW    = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [WIDTH-1:0]       src_mant_q;
  logic [EXP_WIDTH-1:0]   src_exp_q;
  logic [TAG_WIDTH-1:0]   src_tag_q;
  logic [CNT_WIDTH-1:0]   acc_q;
  logic                   src_zero_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [WIDTH-1:0]       mant_q;
  logic [EXP_WIDTH-1:0]   exp_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   zero_q;
  logic [TAG_WIDTH-1:0]   tag_q;

  logic [WIDTH-1:0]       mant_sh;
  logic [CHUNK-1:0]       chunk;
  logic [LCW-1:0]         lzc_cnt;
  logic                   lzc_empty;
  logic [CNT_WIDTH-1:0]   cnt_d;

  // select the chunk under scan by aligning it to the MSB
  always_comb begin
    mant_sh = src_mant_q << (int'(idx_q) * int'(CHUNK));
    chunk   = mant_sh[WIDTH-1 -: CHUNK];
    cnt_d   = CNT_WIDTH'(idx_q) * CNT_WIDTH'(CHUNK)
            + CNT_WIDTH'(lzc_cnt);
  end

  lzc #(
    .WIDTH (CHUNK),
    .MODE  (1'b1)
  ) u_lzc (
    .in_i    (chunk),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  // control FSM with registered handshake and result outputs;
  // DONE spends one settle cycle before raising out_valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      src_mant_q  <= '0;
      src_exp_q   <= '0;
      src_tag_q   <= '0;
      acc_q       <= '0;
      src_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      tag_q       <= '0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            src_mant_q <= mant_i;
            src_exp_q  <= exp_i;
            src_tag_q  <= tag_i;
            acc_q      <= '0;
            src_zero_q <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (!lzc_empty) begin
            acc_q   <= cnt_d;
            state_q <= SHIFT;
          end else if (idx_q == IDX_W'(NCHUNK - 1)) begin
            acc_q      <= CNT_WIDTH'(WIDTH);
            src_zero_q <= 1'b1;
            state_q    <= SHIFT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SHIFT: begin
          mant_q  <= src_mant_q << acc_q;
          exp_q   <= src_exp_q - EXP_WIDTH'(acc_q);
          cnt_q   <= acc_q;
          zero_q  <= src_zero_q;
          tag_q   <= src_tag_q;
          state_q <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign mant_o      = mant_q;
  assign exp_o       = exp_q;
  assign cnt_o       = cnt_q;
  assign zero_o      = zero_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_lzc_norm_seq.sv
// Directed bench for lzc_norm_seq: vector table plus
// backpressure, flush and async-reset sequences.

module tb_lzc_norm_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] mant_in;
  logic [9:0]  exp_in;
  logic [1:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] mant_out;
  logic [9:0]  exp_out;
  logic [5:0]  cnt_out;
  logic        zero_out;
  logic [1:0]  tag_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] mant;
    logic [9:0]  expn;
    logic [1:0]  tag;
    logic [5:0]  cnt_x;
    logic [47:0] mant_x;
    logic [9:0]  exp_x;
    logic        zero_x;
    int          lat_x;
  } vec_t;

  vec_t vecs [7];

  lzc_norm_seq dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mant_i      (mant_in),
    .exp_i       (exp_in),
    .tag_i       (tag_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .mant_o      (mant_out),
    .exp_o       (exp_out),
    .cnt_o       (cnt_out),
    .zero_o      (zero_out),
    .tag_o       (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // wait for out_valid, bounded; returns cycles after the accept edge
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic accept(input vec_t v);
    @(negedge clk);
    in_valid = 1'b1;
    mant_in  = v.mant;
    exp_in   = v.expn;
    tag_in   = v.tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mant_in  = 48'hDEAD_BEEF_0123;
    exp_in   = 10'h2AA;
    tag_in   = ~v.tag;
  endtask

  task automatic check_result(input vec_t v);
    check("cnt", 64'(cnt_out), 64'(v.cnt_x));
    check("mant", 64'(mant_out), 64'(v.mant_x));
    check("exp", 64'(exp_out), 64'(v.exp_x));
    check("zero", 64'(zero_out), 64'(v.zero_x));
    check("tag", 64'(tag_out), 64'(v.tag));
    check("rdy_in_done", 64'(in_ready), 64'd0);
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    accept(v);
    wait_valid(lat);
    check("latency", 64'(lat), 64'(v.lat_x));
    check_result(v);
    release_out();
  endtask

  initial begin
    int lat;
    logic [47:0] m_s;
    logic [9:0]  e_s;
    logic [5:0]  c_s;
    bit seen;

    vecs[0] = '{48'h8000_0000_0000, 10'd5,   2'b00, 6'd0,
                48'h8000_0000_0000, 10'd5,   1'b0, 3};
    vecs[1] = '{48'h0000_0001_0000, 10'd5,   2'b10, 6'd31,
                48'h8000_0000_0000, 10'h3E6, 1'b0, 4};
    vecs[2] = '{48'h0000_0000_0000, 10'd0,   2'b01, 6'd48,
                48'h0000_0000_0000, 10'h3D0, 1'b1, 5};
    vecs[3] = '{48'h0000_0000_0001, 10'd100, 2'b11, 6'd47,
                48'h8000_0000_0000, 10'h035, 1'b0, 5};
    vecs[4] = '{48'h0001_2345_6789, 10'h1FF, 2'b01, 6'd15,
                48'h91A2_B3C4_8000, 10'h1F0, 1'b0, 3};
    vecs[5] = '{48'h0000_8000_0000, 10'h200, 2'b10, 6'd16,
                48'h8000_0000_0000, 10'h1F0, 1'b0, 4};
    vecs[6] = '{48'h0000_0000_FFFF, 10'h3FF, 2'b00, 6'd32,
                48'hFFFF_0000_0000, 10'h3DF, 1'b0, 5};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_in   = '0;
    exp_in    = '0;
    tag_in    = '0;
    #12;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_mant", 64'(mant_out), 64'd0);
    check("rst_cnt", 64'(cnt_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // backpressure: outputs hold, in_valid ignored while in DONE
    accept(vecs[1]);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd4);
    m_s = mant_out;
    e_s = exp_out;
    c_s = cnt_out;
    @(negedge clk);
    in_valid = 1'b1;
    mant_in  = 48'h0000_0000_00F0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_mant", 64'(mant_out), 64'(m_s));
      check("bp_exp", 64'(exp_out), 64'(e_s));
      check("bp_cnt", 64'(cnt_out), 64'(c_s));
    end
    in_valid = 1'b0;
    check_result(vecs[1]);
    release_out();
    run_op(vecs[4]);

    // flush in the second SCAN cycle
    accept(vecs[3]);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_ready", 64'(in_ready), 64'd1);
    check("fl_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("fl_never_valid", 64'(seen), 64'd0);
    run_op(vecs[3]);

    // async reset while in SHIFT
    accept(vecs[1]);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("ar_ready", 64'(in_ready), 64'd1);
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_mant", 64'(mant_out), 64'd0);
    check("ar_exp", 64'(exp_out), 64'd0);
    check("ar_cnt", 64'(cnt_out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzc_norm_seq.md
Name: lzc_norm_seq

Overview:
Iterative mantissa normalizer for the FPU datapath. It shares one narrow leading-zero counter across a wide mantissa, scanning CHUNK bits per cycle from the MSB side, then left-shifts the mantissa and adjusts the exponent. It sits between the FMA/add result stage and rounding, replacing a full-width LZC with a sequenced, area-cheap unit behind valid/ready handshakes.

Parameters:
WIDTH, 48, mantissa width in bits; must be an integer multiple of CHUNK.
CHUNK, 16, bits scanned per cycle; this is the WIDTH of the single internal lzc instance (MODE=1'b1).
EXP_WIDTH, 10, signed exponent width.
TAG_WIDTH, 2, opaque tag width, passed through unchanged.
Derived: NCHUNK = WIDTH/CHUNK; CNT_WIDTH = $clog2(WIDTH+1).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  asynchronous active-low reset.
flush_i  in  1  synchronous abort of any in-flight operation.
in_valid_i  in  1  request valid.
in_ready_o  out  1  high only in IDLE.
mant_i  in  WIDTH  unnormalized mantissa.
exp_i  in  EXP_WIDTH  signed exponent.
tag_i  in  TAG_WIDTH  opaque tag.
out_valid_o  out  1  result valid; high only in DONE.
out_ready_i  in  1  consumer accept.
mant_o  out  WIDTH  normalized mantissa, MSB set unless zero.
exp_o  out  EXP_WIDTH  exp_i minus cnt_o, wrapping modulo 2^EXP_WIDTH.
cnt_o  out  CNT_WIDTH  leading-zero count, 0..WIDTH.
zero_o  out  1  mant_i was all zeros.
tag_o  out  TAG_WIDTH  captured tag_i.

Behaviour:
- Reset (async assert, sync-safe release): state IDLE, chunk index 0, all output registers 0, out_valid_o=0, in_ready_o=1.
- FSM: IDLE, SCAN, SHIFT, DONE.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o, capture mant_i, exp_i and tag_i, clear the count accumulator, set idx=0, go to SCAN.
- SCAN: feed chunk idx into the lzc. Chunk 0 is mant[WIDTH-1 -: CHUNK]; chunk k is mant[WIDTH-1-k*CHUNK -: CHUNK].
  - Chunk non-empty: cnt = idx*CHUNK + lzc count; go to SHIFT.
  - Chunk empty, idx < NCHUNK-1: idx++, stay in SCAN.
  - Chunk empty, idx = NCHUNK-1: cnt = WIDTH, zero flag = 1; go to SHIFT.
- SHIFT (one cycle): mant_o <= mant << cnt (zero when cnt=WIDTH); exp_o <= exp - cnt, computed in EXP_WIDTH bits with cnt zero-extended, no saturation; cnt_o, zero_o and tag_o registered. Go to DONE.
- DONE: out_valid_o=1. All outputs stay stable until out_ready_i. On out_ready_i go to IDLE. There is no same-cycle re-accept, so in_ready_o stays 0 in DONE.
- Latency: with n = index of the first non-zero chunk + 1 (NCHUNK if all zero), out_valid_o rises n+2 cycles after the accept edge.
- Throughput: one operation at a time.
- flush_i: in any state, next state is IDLE and out_valid_o=0 next cycle. flush_i has priority over accept and over out_ready_i. Output data registers need not clear.
- in_valid_i outside IDLE is ignored; mant_i is not sampled.
- Reset mid-operation: immediate return to reset values; the operation is dropped silently.

Test Plan:
- mant_i=48'h8000_0000_0000, exp_i=5 -> cnt_o=0, mant_o unchanged, exp_o=5, zero_o=0; out_valid_o 3 cycles after accept.
- mant_i=48'h0000_0001_0000, exp_i=10'sd5, tag_i=2'b10 -> cnt_o=31, mant_o=48'h8000_0000_0000, exp_o=10'h3E6 (-26), tag_o=2'b10; latency 4 cycles.
- mant_i=0, exp_i=0 -> cnt_o=48, zero_o=1, mant_o=0, exp_o=10'h3D0; latency 5 cycles.
- Backpressure: hold out_ready_i=0 for 4 cycles in DONE -> all outputs stable, in_ready_o=0, a held in_valid_i is ignored; the accept after return to IDLE yields the correct second result.
- Raise flush_i in the second SCAN cycle of mant_i=48'h0000_0000_0001 -> IDLE next cycle, out_valid_o never asserts, in_ready_o=1; the next request completes normally.
- Assert rst_ni=0 asynchronously while in SHIFT -> outputs 0 and in_ready_o=1 without waiting for a clock edge; a request after release completes with correct values.
